ram_rd_checker: RTL and testbench

Read-side verifier for the dual-port block RAM test design. The writer fills port A and raises `rd_flag`; this block detects the rising edge, sweeps port B over every address, and compares each returned word against the known write pattern. It reports per-pass error count, a sticky error flag, the first failing address and a pass counter for ILA probing.

---
 rtl/ram_rd_checker.sv | 96 +++++++++
 tb/tb_ram_rd_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ram_rd_checker.sv
// ram_rd_checker: sweeps RAM port B after a rd_flag rising edge and checks each word against the write pattern
module ram_rd_checker #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int RD_LAT  = 1,
  parameter int PAT_OFS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_flag,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              pass_done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t              r_state, w_next;
  logic                r_rd_flag_d;
  logic [1:0]          r_drn;
  logic [RD_LAT-1:0]   r_vld;
  logic [ADDR_W-1:0]   r_adly [RD_LAT];
  logic                w_edge, w_last, w_dend, w_start, w_mis;
  logic [DATA_W-1:0]   w_exp;
  assign w_edge  = rd_flag & ~r_rd_flag_d;
  assign w_start = (r_state == S_IDLE) & w_edge;
  assign w_last  = ram_rd_addr == ADDR_W'(DEPTH - 1);
  assign w_dend  = r_drn == 2'(RD_LAT - 1);
  assign w_exp   = DATA_W'(r_adly[RD_LAT-1]) + DATA_W'(PAT_OFS);
  assign w_mis   = r_vld[RD_LAT-1] & (ram_rd_data != w_exp);
  // state register and rd_flag edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_flag_d <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rd_flag_d <= rd_flag;
    end
  end
  // next state: edges outside IDLE fall through unnoticed
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_edge ? S_READ : S_IDLE;
      S_READ:  w_next = w_last ? S_DRAIN : S_READ;
      S_DRAIN: w_next = w_dend ? S_DONE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end
  // registered outputs, address sweep, drain timer and error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd_en      <= 1'b0;
      ram_rd_addr    <= '0;
      busy           <= 1'b0;
      pass_done      <= 1'b0;
      pass_cnt       <= '0;
      r_drn          <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      ram_rd_en <= w_next == S_READ;
      busy      <= w_next != S_IDLE;
      pass_done <= w_next == S_DONE;
      if (w_next == S_DONE) pass_cnt <= pass_cnt + 16'd1;
      if (w_start) ram_rd_addr <= '0;
      else if (r_state == S_READ && !w_last) ram_rd_addr <= ram_rd_addr + 1'b1;
      r_drn <= (r_state == S_DRAIN) ? r_drn + 2'd1 : 2'd0;
      if (w_start) err_cnt <= '0;
      else if (w_mis) err_cnt <= err_cnt + 1'b1;
      if (w_mis) err_flag <= 1'b1;
      if (w_mis && !err_flag) first_err_addr <= r_adly[RD_LAT-1];
    end
  end
  // address/valid delay line aligning each request with its returned word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_adly[i] <= '0;
    end else begin
      r_vld[0]  <= ram_rd_en;
      r_adly[0] <= ram_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_adly[i] <= r_adly[i-1];
      end
    end
  end
endmodule

// File: tb/tb_ram_rd_checker.sv
// tb_ram_rd_checker: directed checks of ram_rd_checker with 1- and 2-cycle RAM models
module tb_ram_rd_checker;
  logic clk = 0, rst = 1, flag0 = 0, flag1 = 0;
  logic en0, en1, busy0, busy1, pd0, pd1, ef0, ef1;
  logic [5:0] addr0, addr1, fe0, fe1;
  logic [7:0] dout0, dout1, d1;
  logic [6:0] ec0, ec1;
  logic [15:0] pc0, pc1;
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int n_cmp = 0, n_mis = 0;
  int done_at, pd_cnt, en_cnt, ec_pd, busy_pd;
  bit seq_ok;
  always #5 clk = ~clk;
  ram_rd_checker dut0 (.clk(clk), .rst(rst), .rd_flag(flag0), .ram_rd_en(en0), .ram_rd_addr(addr0),
    .ram_rd_data(dout0), .busy(busy0), .pass_done(pd0), .err_cnt(ec0), .err_flag(ef0),
    .first_err_addr(fe0), .pass_cnt(pc0));
  ram_rd_checker #(.RD_LAT(2)) dut1 (.clk(clk), .rst(rst), .rd_flag(flag1), .ram_rd_en(en1), .ram_rd_addr(addr1),
    .ram_rd_data(dout1), .busy(busy1), .pass_done(pd1), .err_cnt(ec1), .err_flag(ef1),
    .first_err_addr(fe1), .pass_cnt(pc1));
  always @(posedge clk) if (en0) dout0 <= mem0[addr0];
  always @(posedge clk) begin
    if (en1) d1 <= mem1[addr1];
    dout1 <= d1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start(input int sel);
    @(negedge clk);
    if (sel == 0) flag0 = 0; else flag1 = 0;
    @(negedge clk);
    if (sel == 0) flag0 = 1; else flag1 = 1;
  endtask
  task automatic watch(input int sel, input int ncyc, input bit tog);
    logic e, p, b;
    logic [5:0] a;
    done_at = -1; pd_cnt = 0; en_cnt = 0; ec_pd = -1; busy_pd = 0; seq_ok = 1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (tog && n == 5) flag0 = 0;
      if (tog && n == 8) flag0 = 1;
      e = sel ? en1 : en0;
      a = sel ? addr1 : addr0;
      p = sel ? pd1 : pd0;
      b = sel ? busy1 : busy0;
      if (e) begin
        if (int'(a) != en_cnt) seq_ok = 0;
        en_cnt++;
      end
      if (p) begin
        pd_cnt++;
        if (done_at < 0) begin
          done_at = n;
          ec_pd = int'(sel ? ec1 : ec0);
          busy_pd = int'(b);
        end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 8'(i);
      mem1[i] = 8'(i);
    end
    mem1[63] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_en", en0, 1'b0);
    chk("rst_addr", addr0, 6'd0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_pd", pd0, 1'b0);
    chk("rst_errcnt", ec0, 7'd0);
    chk("rst_errflag", ef0, 1'b0);
    chk("rst_pcnt", pc0, 16'd0);
    chk("rst_pcnt_l2", pc1, 16'd0);
    rst = 0;
    start(0);
    watch(0, 70, 0);
    chk("clean_done_at", done_at, 66);
    chk("clean_en_cnt", en_cnt, 64);
    chk("clean_seq", seq_ok, 1'b1);
    chk("clean_errcnt", ec_pd, 0);
    chk("clean_busy_pd", busy_pd, 1);
    chk("clean_busy_after", busy0, 1'b0);
    chk("clean_errflag", ef0, 1'b0);
    chk("clean_pcnt", pc0, 16'd1);
    mem0[5] = 8'hA5;
    mem0[40] = 8'h00;
    start(0);
    watch(0, 70, 0);
    chk("inj_done_at", done_at, 66);
    chk("inj_errcnt", ec_pd, 2);
    chk("inj_errflag", ef0, 1'b1);
    chk("inj_first", fe0, 6'd5);
    chk("inj_pcnt", pc0, 16'd2);
    mem0[5] = 8'h05;
    mem0[40] = 8'h28;
    start(0);
    watch(0, 70, 0);
    chk("sticky_errcnt", ec_pd, 0);
    chk("sticky_errflag", ef0, 1'b1);
    chk("sticky_first", fe0, 6'd5);
    chk("sticky_pcnt", pc0, 16'd3);
    start(0);
    watch(0, 150, 1);
    chk("ign_pd_cnt", pd_cnt, 1);
    chk("ign_done_at", done_at, 66);
    chk("ign_en_cnt", en_cnt, 64);
    chk("ign_pcnt", pc0, 16'd4);
    start(0);
    for (int n = 0; n < 40 && !(en0 && addr0 == 6'd30); n++) @(negedge clk);
    chk("mid_reached30", addr0, 6'd30);
    rst = 1;
    flag0 = 0;
    @(negedge clk);
    chk("mid_en", en0, 1'b0);
    chk("mid_addr", addr0, 6'd0);
    chk("mid_busy", busy0, 1'b0);
    chk("mid_errflag", ef0, 1'b0);
    chk("mid_first", fe0, 6'd0);
    chk("mid_pcnt", pc0, 16'd0);
    rst = 0;
    start(0);
    watch(0, 70, 0);
    chk("post_done_at", done_at, 66);
    chk("post_en_cnt", en_cnt, 64);
    chk("post_seq", seq_ok, 1'b1);
    chk("post_errcnt", ec_pd, 0);
    chk("post_errflag", ef0, 1'b0);
    chk("post_pcnt", pc0, 16'd1);
    start(1);
    watch(1, 72, 0);
    chk("l2_done_at", done_at, 67);
    chk("l2_en_cnt", en_cnt, 64);
    chk("l2_errcnt", ec_pd, 1);
    chk("l2_errflag", ef1, 1'b1);
    chk("l2_first", fe1, 6'd63);
    chk("l2_pcnt", pc1, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
